// File: rtl/icache_nway_if.sv
// Fetch-side, flush, refill and counter signals of the N-way instruction cache.
// The cache uses the slave modport; the IF stage and AXI read master use the master modport.
interface icache_nway_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 16
);
    localparam int unsigned LINE_W = LINE_BYTES * 8;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              kill;
    logic              resp_valid;
    logic [63:0]       resp_data;
    logic              flush;
    logic              flush_busy;
    logic              axi_req_valid;
    logic              axi_req_ready;
    logic [ADDR_W-1:0] axi_req_addr;
    logic              axi_res_valid;
    logic [LINE_W-1:0] axi_res_data;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    modport master (
        output req_valid, req_addr, kill, flush, axi_req_ready, axi_res_valid, axi_res_data,
        input  req_ready, resp_valid, resp_data, flush_busy, axi_req_valid, axi_req_addr,
               hit_cnt, miss_cnt
    );

    modport slave (
        input  req_valid, req_addr, kill, flush, axi_req_ready, axi_res_valid, axi_res_data,
        output req_ready, resp_valid, resp_data, flush_busy, axi_req_valid, axi_req_addr,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with per-set round-robin replacement,
// fence.i flush, redirect kill and a single-beat refill handshake.
module icache_nway #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    icache_nway_if.slave bus
);
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned WORD_W = (OFF_W > 3) ? OFF_W - 3 : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, REPLY, FLUSH} state_t;

    state_t                          state, state_nx;
    logic [ADDR_W-1:0]               addr_q;
    logic [SETS-1:0][WAYS-1:0]       valid_q;
    logic [SETS-1:0][WAY_W-1:0]      rr_ptr;
    logic [TAG_W-1:0]                tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0]               data_mem [SETS][WAYS];
    logic [WAY_W-1:0]                victim_q, victim_c, hit_way;
    logic                            hit, flush_pend, kill_pend;
    logic                            req_ready_c, accept, refill, miss_state;
    logic                            resp_valid_c, axi_req_valid_c;
    logic [31:0]                     hit_cnt_q, miss_cnt_q;
    logic [IDX_W-1:0]                idx;
    logic [TAG_W-1:0]                tag;
    logic [WORD_W-1:0]               word;
    logic [LINE_W-1:0]               line_sel;

    assign idx  = addr_q[OFF_W +: IDX_W];
    assign tag  = addr_q[ADDR_W-1 -: TAG_W];
    assign word = WORD_W'(addr_q[OFF_W-1:0] >> 3);

    // Tag compare (lowest hitting way wins) and victim choice (lowest invalid, else rr)
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        victim_c = rr_ptr[idx];
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) victim_c = WAY_W'(w);
        end
    end

    assign req_ready_c = ((state == IDLE) || ((state == LOOKUP) && hit)) && !bus.flush && !flush_pend;
    assign accept      = bus.req_valid && req_ready_c;
    assign refill      = (state == REFILL_WAIT) && bus.axi_res_valid;
    assign miss_state  = ((state == LOOKUP) && !hit) || (state == REFILL_REQ) || (state == REFILL_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        resp_valid_c    = 1'b0;
        axi_req_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.flush || flush_pend) state_nx = FLUSH;
                else if (accept)             state_nx = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid_c = !bus.kill;
                    state_nx     = accept ? LOOKUP : IDLE;
                end else begin
                    state_nx = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                axi_req_valid_c = 1'b1;
                if (bus.axi_req_ready) state_nx = REFILL_WAIT;
            end
            REFILL_WAIT: if (bus.axi_res_valid) state_nx = REPLY;
            REPLY: begin
                resp_valid_c = !bus.kill && !kill_pend;
                state_nx     = IDLE;
            end
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request address, pending flush/kill, victim and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            flush_pend <= 1'b0;
            kill_pend  <= 1'b0;
            victim_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (accept) addr_q <= bus.req_addr;
            if (state == FLUSH)                      flush_pend <= 1'b0;
            else if (bus.flush && (state != IDLE))   flush_pend <= 1'b1;
            if (state == REPLY)                      kill_pend  <= 1'b0;
            else if (bus.kill && miss_state)         kill_pend  <= 1'b1;
            if ((state == LOOKUP) && hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            if ((state == LOOKUP) && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
                victim_q   <= victim_c;
            end
        end
    end

    // Valid bits and round-robin pointers; flush leaves the pointers alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rr_ptr  <= '0;
        end else if (state == FLUSH) begin
            valid_q <= '0;
        end else if (refill) begin
            valid_q[idx][victim_q] <= 1'b1;
            if (victim_q == rr_ptr[idx])
                rr_ptr[idx] <= (rr_ptr[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[idx] + WAY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (refill) begin
            tag_mem[idx][victim_q]  <= tag;
            data_mem[idx][victim_q] <= bus.axi_res_data;
        end
    end

    // REPLY reads the freshly installed victim line, LOOKUP the hitting way
    assign line_sel          = data_mem[idx][(state == REPLY) ? victim_q : hit_way];
    assign bus.resp_data     = 64'(line_sel >> {word, 6'd0});
    assign bus.resp_valid    = resp_valid_c;
    assign bus.req_ready     = req_ready_c;
    assign bus.axi_req_valid = axi_req_valid_c;
    assign bus.axi_req_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.flush_busy    = flush_pend || (state == FLUSH);
    assign bus.hit_cnt       = hit_cnt_q;
    assign bus.miss_cnt      = miss_cnt_q;
endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway: directed table, hand sequences and random fetches
// compared with a line-address based cache model.
module tb_icache_nway;
    localparam int unsigned WAYS       = 4;
    localparam int unsigned SETS       = 64;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_W     = LINE_BYTES * 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_nway_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES)) bus ();

    icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each set holds line addresses; rr pointer per set
    bit          m_valid [SETS][WAYS];
    logic [31:0] m_line  [SETS][WAYS];
    int          m_rr    [SETS];
    int unsigned m_hits, m_misses;

    typedef struct {
        logic [31:0] addr;
        int          kmode;
        bit          fl;
        bit          exp_miss;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_dw(input logic [31:0] line, input int w);
        if (line == 32'h8000_0000 && w == 1) return 64'h1111_2222_3333_4444;
        return {line ^ 32'h5A5A_0000, 32'(w) ^ ~line};
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] line);
        logic [LINE_W-1:0] d;
        for (int w = 0; w < int'(LINE_BYTES / 8); w++) d[w*64 +: 64] = mem_dw(line, w);
        return d;
    endfunction

    function automatic int m_find(input logic [31:0] a);
        int s = int'((a / LINE_BYTES) % SETS);
        logic [31:0] la = a - (a % LINE_BYTES);
        for (int w = 0; w < int'(WAYS); w++)
            if (m_valid[s][w] && m_line[s][w] == la) return w;
        return -1;
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        int s = int'((a / LINE_BYTES) % SETS);
        int v = -1;
        for (int w = 0; w < int'(WAYS); w++)
            if (!m_valid[s][w] && v < 0) v = w;
        if (v < 0) v = m_rr[s];
        m_valid[s][v] = 1'b1;
        m_line[s][v]  = a - (a % LINE_BYTES);
        if (v == m_rr[s]) m_rr[s] = (m_rr[s] + 1) % int'(WAYS);
    endfunction

    function automatic void m_clear(input bit full);
        for (int s = 0; s < int'(SETS); s++) begin
            for (int w = 0; w < int'(WAYS); w++) m_valid[s][w] = 1'b0;
            if (full) m_rr[s] = 0;
        end
        if (full) begin
            m_hits   = 0;
            m_misses = 0;
        end
    endfunction

    // One fetch; kmode 0 none, 1 kill in the lookup cycle, 2 kill during refill wait
    task automatic fetch(input logic [31:0] a, input int kmode, input bit fl,
                         output bit miss, output bit got_resp, output logic [63:0] data);
        int n;
        bit held;
        logic [31:0] la;
        la = a - (a % LINE_BYTES);
        miss = 1'b0; got_resp = 1'b0; data = '0; held = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) chk("ready_timeout", 0, 1);
        @(negedge clk); bus.req_valid = 1'b1; bus.req_addr = a;
        @(negedge clk); bus.req_valid = 1'b0; bus.kill = (kmode == 1); #1;
        if (bus.resp_valid) begin got_resp = 1'b1; data = bus.resp_data; end
        if (bus.req_ready) begin
            @(negedge clk); bus.kill = 1'b0; #1;
            return;
        end
        miss = 1'b1;
        @(negedge clk); bus.kill = 1'b0; #1;
        chk("axi_req_valid", bus.axi_req_valid, 1);
        chk("axi_req_addr", bus.axi_req_addr, la);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); bus.axi_res_valid = 1'b1; bus.axi_res_data = '1; #1;
            if (!bus.axi_req_valid || bus.axi_req_addr !== la) held = 1'b0;
        end
        @(negedge clk); bus.axi_res_valid = 1'b0; bus.axi_req_ready = 1'b1; #1;
        if (!bus.axi_req_valid || bus.axi_req_addr !== la) held = 1'b0;
        chk("axi_req_held", held, 1);
        @(negedge clk); bus.axi_req_ready = 1'b0; bus.kill = (kmode == 2); bus.flush = fl;
        repeat ($urandom_range(0, 2)) begin @(negedge clk); bus.kill = 1'b0; bus.flush = 1'b0; end
        bus.axi_res_valid = 1'b1; bus.axi_res_data = mem_line(la);
        @(negedge clk); bus.axi_res_valid = 1'b0; bus.kill = 1'b0; bus.flush = 1'b0; #1;
        if (bus.resp_valid) begin got_resp = 1'b1; data = bus.resp_data; end
        if (fl) begin
            chk("flush_busy_reply", bus.flush_busy, 1);
            chk("req_ready_while_busy", bus.req_ready, 0);
        end
        n = 0;
        while (!bus.req_ready && n < 10) begin @(negedge clk); #1; n++; end
        if (n >= 10) chk("idle_timeout", 0, 1);
    endtask

    task automatic run(input string name, input logic [31:0] a, input int kmode, input bit fl,
                       output bit miss);
        bit exp_miss, exp_resp, got_resp;
        logic [63:0] d;
        exp_miss = (m_find(a) < 0);
        fetch(a, kmode, fl, miss, got_resp, d);
        chk({name, "_miss"}, miss, exp_miss);
        if (exp_miss) begin m_fill(a); m_misses++; end
        else m_hits++;
        exp_resp = exp_miss ? (kmode == 0) : (kmode != 1);
        chk({name, "_resp"}, got_resp, exp_resp);
        if (exp_resp && got_resp)
            chk({name, "_data"}, d, mem_dw(a - (a % LINE_BYTES), int'((a % LINE_BYTES) / 8)));
        if (fl && miss) m_clear(1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit miss;
        int r;
        logic [31:0] a;
        bus.req_valid = 0; bus.req_addr = '0; bus.kill = 0; bus.flush = 0;
        bus.axi_req_ready = 0; bus.axi_res_valid = 0; bus.axi_res_data = '0;
        rst = 1'b1;
        m_clear(1'b1);
        tbl[0]  = '{32'h8000_0400, 0, 1'b0, 1'b1};
        tbl[1]  = '{32'h8000_0800, 0, 1'b0, 1'b1};
        tbl[2]  = '{32'h8000_0C00, 0, 1'b0, 1'b1};
        tbl[3]  = '{32'h8000_1008, 0, 1'b0, 1'b1};
        tbl[4]  = '{32'h8000_0000, 0, 1'b0, 1'b1};
        tbl[5]  = '{32'h8000_0C08, 0, 1'b0, 1'b0};
        tbl[6]  = '{32'h8000_0400, 2, 1'b0, 1'b1};
        tbl[7]  = '{32'h8000_0400, 0, 1'b0, 1'b0};
        tbl[8]  = '{32'h8000_1000, 1, 1'b0, 1'b0};
        tbl[9]  = '{32'h8000_0800, 0, 1'b1, 1'b1};
        tbl[10] = '{32'h8000_0C00, 0, 1'b0, 1'b1};
        tbl[11] = '{32'h8000_0000, 0, 1'b0, 1'b1};
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;

        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_axi_req_valid", bus.axi_req_valid, 0);
        chk("rst_axi_req_addr", bus.axi_req_addr, 0);
        chk("rst_flush_busy", bus.flush_busy, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_hit_cnt", bus.hit_cnt, 0);

        run("cold", 32'h8000_0008, 0, 1'b0, miss);
        chk("cold_miss_cnt", bus.miss_cnt, 1);

        // Back-to-back hits
        @(negedge clk); bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0000;
        @(negedge clk); bus.req_addr = 32'h8000_0008; #1;
        chk("stream0_valid", bus.resp_valid, 1);
        chk("stream0_data", bus.resp_data, mem_dw(32'h8000_0000, 0));
        chk("stream0_ready", bus.req_ready, 1);
        @(negedge clk); bus.req_valid = 1'b0; #1;
        chk("stream1_valid", bus.resp_valid, 1);
        chk("stream1_data", bus.resp_data, 64'h1111_2222_3333_4444);
        chk("stream1_no_axi", bus.axi_req_valid, 0);
        @(negedge clk); #1;
        chk("stream_hit_cnt", bus.hit_cnt, 2);
        m_hits += 2;

        for (int i = 0; i < 12; i++) begin
            run($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].kmode, tbl[i].fl, miss);
            chk($sformatf("tbl%0d_table_miss", i), miss, tbl[i].exp_miss);
        end
        chk("tbl_hit_cnt", bus.hit_cnt, m_hits);
        chk("tbl_miss_cnt", bus.miss_cnt, m_misses);

        // Flush raised in IDLE blocks the concurrent request
        @(negedge clk); bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0C00; #1;
        chk("idle_flush_ready", bus.req_ready, 0);
        @(negedge clk); bus.flush = 1'b0; bus.req_valid = 1'b0; #1;
        chk("flush_state_busy", bus.flush_busy, 1);
        chk("flush_state_ready", bus.req_ready, 0);
        @(negedge clk); #1;
        chk("flush_done_busy", bus.flush_busy, 0);
        m_clear(1'b0);
        run("post_flush", 32'h8000_0C00, 0, 1'b0, miss);

        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 99));
            a = 32'h4000_0000 + ($urandom % 6) * 32'h400 + ($urandom % 3) * 32'h10
                + ($urandom % 2) * 32'h8 + ($urandom % 8);
            run("rnd", a, (r < 70) ? 0 : (r < 85) ? 1 : 2, ($urandom % 12) == 0, miss);
        end
        chk("rnd_hit_cnt", bus.hit_cnt, m_hits);
        chk("rnd_miss_cnt", bus.miss_cnt, m_misses);

        // Asynchronous reset while the refill request is outstanding
        @(negedge clk); bus.req_valid = 1'b1; bus.req_addr = 32'h9000_0000;
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_axi_valid", bus.axi_req_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_axi_valid", bus.axi_req_valid, 0);
        chk("async_rst_hit_cnt", bus.hit_cnt, 0);
        chk("async_rst_miss_cnt", bus.miss_cnt, 0);
        @(negedge clk); rst = 1'b0; #1;
        m_clear(1'b1);
        run("after_rst", 32'h8000_0008, 0, 1'b0, miss);
        run("after_rst_rnd", a, 0, 1'b0, miss);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative instruction cache; successor to the fixed 2-way/128-set IF-stage cache.
- Sits between the IF stage and the AXI read master.
- Adds per-set round-robin replacement, fence.i flush, redirect kill, a valid/ready refill handshake and hit/miss counters.
- Line storage is flop arrays, so there is no SRAM-macro read latency.

Parameters:
- WAYS, 4, associativity (power of two, 1..8)
- SETS, 64, number of sets (power of two)
- LINE_BYTES, 16, line size (power of two, >=8)
- ADDR_W, 32, fetch address width
- Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  fetch request
- req_ready  out  1  cache can accept a request this cycle
- req_addr  in  ADDR_W  fetch address; bits[2:0] ignored
- kill  in  1  pipeline redirect; drops the outstanding response
- resp_valid  out  1  one-cycle pulse, resp_data valid
- resp_data  out  64  selected doubleword
- flush  in  1  fence.i pulse; invalidate all lines
- flush_busy  out  1  flush pending or executing
- axi_req_valid  out  1  refill read request
- axi_req_ready  in  1  request accepted
- axi_req_addr  out  ADDR_W  line-aligned address (low OFF_W bits zero)
- axi_res_valid  in  1  refill data valid, single beat
- axi_res_data  in  LINE_BYTES*8  whole line
- hit_cnt  out  32  hit counter, wraps
- miss_cnt  out  32  miss counter, wraps

Behaviour:
Reset and handshake
- Reset (async assert, sync release) clears all valid bits and round-robin pointers, flush_pend, both counters and the address register; state=IDLE.
- After reset, resp_valid=0, axi_req_valid=0, axi_req_addr=0, flush_busy=0.
- req_ready = (state==IDLE or (state==LOOKUP and hit)) and !flush and !flush_pend.
- A request is accepted when req_valid & req_ready; the address is registered.

State machine (IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, REPLY, FLUSH)
- IDLE:
  - flush or flush_pend -> FLUSH.
  - Accept -> LOOKUP.
- LOOKUP: compare tags of all ways of the indexed set.
  - Hit: resp_valid=1 this cycle (1-cycle latency), hit_cnt+1. Next state is LOOKUP if a new request is accepted, else IDLE.
  - Miss: miss_cnt+1 -> REFILL_REQ.
  - Victim = lowest-index invalid way; if none, rr_ptr[set].
  - Multiple-way hit is illegal; the lowest way wins.
- REFILL_REQ:
  - axi_req_valid=1; axi_req_addr = registered addr with offset bits cleared.
  - Both are held stable until axi_req_ready; then -> REFILL_WAIT.
- REFILL_WAIT: on axi_res_valid:
  - Write line, tag and valid to the victim.
  - If the victim equals rr_ptr, rr_ptr+1 mod WAYS.
  - -> REPLY.
- REPLY: resp_valid=1 with the word from the new line -> IDLE. Miss latency = handshake + response + 1.
- FLUSH: clear every valid bit in one cycle; flush_pend=0 -> IDLE. rr pointers are unchanged.

Word select and kill
- resp_data = line[word*64 +: 64], where word = addr[OFF_W-1:3].
- kill during LOOKUP-hit or REPLY suppresses resp_valid.
- kill during a miss: the refill still completes and installs the line; REPLY emits no resp_valid. kill_pend is held until REPLY.
- kill in the same cycle as an accept does not cancel the new request.

Flush
- flush outside IDLE sets flush_pend; it is serviced after the current transaction reaches IDLE.
- flush_busy = flush_pend or state==FLUSH.
- A line refilled before the flush is invalidated by it.

Width rules
- Counters wrap from 0xFFFFFFFF to 0.
- No writes from the core.
- axi_res_valid outside REFILL_WAIT is ignored.

Test Plan:
1. Cold miss:
   - After reset, fetch 0x8000_0008.
   - axi_req_addr=0x8000_0000 held until axi_req_ready.
   - Line returns with dw1=0x1111_2222_3333_4444; resp_data=0x1111_2222_3333_4444 one cycle after axi_res_valid.
   - miss_cnt=1.
2. Hit stream:
   - Refetch 0x8000_0000 then 0x8000_0008 back-to-back.
   - resp_valid on consecutive cycles, no AXI request, hit_cnt=2.
3. Replacement:
   - Fill 5 lines mapping to set 0 (stride SETS*LINE_BYTES=0x400).
   - 5th miss evicts way0; refetching the 1st address misses again.
   - rr_ptr advances 0->1->2.
4. Flush:
   - Assert flush while in REFILL_WAIT; refill completes and flush_busy stays 1.
   - Then all lines are invalid: the next fetch of any prior address misses.
   - req_ready=0 while flush_busy.
5. Kill:
   - Assert kill during REFILL_WAIT; line installed, no resp_valid.
   - An immediate refetch hits with 1-cycle latency.
6. Async reset mid-refill:
   - Assert rst in REFILL_REQ: axi_req_valid drops immediately (no clock edge needed).
   - All lines invalid; counters 0.
